seq_restoring_divider: RTL and testbench

Iterative restoring divider for the ALU. It implements RISC-V M-extension DIV, DIVU, REM and REMU. Each cycle it retires one quotient bit by trial subtraction, which makes it the subtracting counterpart of the ALU's carry-lookahead add path. It sits beside the combinational ALU and is launched by the execute stage with a start/busy/done handshake.

---
 rtl/seq_restoring_divider.sv | 171 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Retires one quotient bit per cycle by trial subtraction, MSB first.
// Divide-by-zero and signed overflow are resolved on the start edge.
// All other operations go through CALC and then FIX. The result appears
// WIDTH+2 cycles after the start cycle.
module seq_restoring_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state_q, state_d;
   logic             op_rem_q, op_rem_d;   // 1: result is the remainder
   logic [WIDTH-1:0] quo_q, quo_d;         // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] rem_q, rem_d;         // partial remainder
   logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qneg_q, qneg_d;       // quotient must be negated in FIX
   logic             rneg_q, rneg_d;       // remainder must be negated in FIX
   logic [WIDTH-1:0] result_q, result_d;

   // Operand decode at launch time
   logic             is_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             div_zero;
   logic             overflow;

   // Iteration datapath
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // Launch decode: magnitudes, signs and the two early-out cases.
   // The magnitude of MOST_NEG is 2^(WIDTH-1), which still fits as an unsigned value.
   always_comb begin
      is_signed = ~op_i[0];
      a_neg     = is_signed & dividend_i[WIDTH-1];
      b_neg     = is_signed & divisor_i[WIDTH-1];
      a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
      b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
      div_zero  = (divisor_i == '0);
      overflow  = is_signed & (dividend_i == MOST_NEG) & (divisor_i == '1);
   end

   // One restoring step.
   // The shifted remainder keeps its carry-out bit, so an unsigned divisor
   // above 2^(WIDTH-1) still divides correctly.
   // diff[WIDTH] is the borrow, meaning the trial subtraction went negative.
   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      q_fix  = qneg_q ? (~quo_q + 1'b1) : quo_q;
      r_fix  = rneg_q ? (~rem_q + 1'b1) : rem_q;
   end

   // Next-state and datapath update. flush_i overrides everything, and nothing
   // else changes on a flush cycle, so result_o holds its value.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d  = state_q;
      op_rem_d = op_rem_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;

      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  op_rem_d = op_i[1];
                  if (div_zero) begin
                     result_d = op_i[1] ? dividend_i : '1;
                     state_d  = S_DONE;
                  end else if (overflow) begin
                     result_d = op_i[1] ? '0 : dividend_i;
                     state_d  = S_DONE;
                  end else begin
                     quo_d   = a_mag;
                     dvs_d   = b_mag;
                     rem_d   = '0;
                     cnt_d   = '0;
                     qneg_d  = a_neg ^ b_neg;
                     rneg_d  = a_neg;
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
               rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               result_d = op_rem_q ? r_fix : q_fix;
               state_d  = S_DONE;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too, so a reset leaves result_o at 0 and nothing stale survives.
         state_q  <= S_IDLE;
         op_rem_q <= 1'b0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q  <= state_d;
         op_rem_q <= op_rem_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=32).
// A table of directed vectors comes first, then hand-written handshake sequences,
// then random operations checked against an arithmetic reference model.
module tb_seq_restoring_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic [1:0]   op_i = 2'b00;
   logic [W-1:0] dividend_i = '0;
   logic [W-1:0] divisor_i = '0;
   logic         flush_i = 1'b0;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] result_o;

   seq_restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start_i),
      .op_i      (op_i),
      .dividend_i(dividend_i),
      .divisor_i (divisor_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model built on the language's own signed and unsigned division
   function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 0) return op[1] ? a : '1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
      case (op)
         2'b00:   return $unsigned(sa / sb);
         2'b01:   return a / b;
         2'b10:   return $unsigned(sa % sb);
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return W + 2;
   endfunction

   // Launch one operation at the next negedge and wait for done_o.
   // If ign > 0, a spurious start with other operands is pulsed in cycle T+ign.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int ign, output logic [W-1:0] res, output int lat,
                         output logic busy_ok);
      @(negedge clk);
      check("idle before start", W'({busy_o, done_o}), '0);
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      @(posedge clk);
      #1;
      start_i    = 1'b0;
      dividend_i = $urandom;
      divisor_i  = $urandom;
      lat        = -1;
      busy_ok    = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (!busy_o) busy_ok = 1'b0;
         if (done_o) begin
            lat = n;
            break;
         end
         start_i = (n == ign);
         if (n == ign) begin
            op_i       = 2'b00;
            dividend_i = 32'd5;
            divisor_i  = 32'd0;
         end
      end
      start_i = 1'b0;
      res     = result_o;
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t         tbl[15];
   logic [W-1:0] res;
   logic [W-1:0] prev;
   int           lat;
   logic         busy_ok;
   logic         saw;

   initial begin
      tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
      tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
      tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
      tbl[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
      tbl[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
      tbl[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      tbl[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
      tbl[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      tbl[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      tbl[9]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          34};
      tbl[10] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34};
      tbl[11] = '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  34};
      tbl[12] = '{2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  34};
      tbl[13] = '{2'b01, 32'd0,          32'd5,          32'd0,          34};
      tbl[14] = '{2'b01, 32'd5,          32'd9,          32'd0,          34};

      // Reset state
      @(negedge clk);
      check("reset busy_o", W'(busy_o), '0);
      check("reset done_o", W'(done_o), '0);
      check("reset result_o", result_o, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table. Consecutive calls also start right after done_o.
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, res, lat, busy_ok);
         check($sformatf("tbl[%0d] result", i), res, tbl[i].exp);
         check($sformatf("tbl[%0d] latency", i), W'(lat), W'(tbl[i].lat));
         check($sformatf("tbl[%0d] busy", i), W'(busy_ok), W'(1));
      end

      // start_i in the DONE cycle is ignored
      start_i    = 1'b1;
      op_i       = 2'b01;
      dividend_i = 32'd9;
      divisor_i  = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      check("start in DONE ignored", W'(busy_o), '0);

      // A start pulsed in cycle T+10 is ignored
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 10, res, lat, busy_ok);
      check("busy start ignored result", res, 32'hFFFF_FFFF);
      check("busy start ignored latency", W'(lat), W'(34));
      check("busy start ignored busy", W'(busy_ok), W'(1));

      // Asynchronous reset in cycle T+15
      @(negedge clk);
      op_i       = 2'b01;
      dividend_i = 32'd100;
      divisor_i  = 32'd7;
      start_i    = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async reset busy_o", W'(busy_o), '0);
      check("async reset done_o", W'(done_o), '0);
      check("async reset result_o", result_o, '0);
      @(negedge clk);
      rst_n = 1'b1;
      saw   = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done_o || busy_o) saw = 1'b1;
      end
      check("no activity after reset", W'(saw), '0);
      run_op(2'b01, 32'd100, 32'd7, 0, res, lat, busy_ok);
      check("after reset result", res, 32'd14);
      check("after reset latency", W'(lat), W'(34));

      // Flush in cycle T+20
      prev = result_o;
      @(negedge clk);
      op_i       = 2'b11;
      dividend_i = 32'd1000;
      divisor_i  = 32'd3;
      start_i    = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush busy_o", W'(busy_o), '0);
      check("flush result held", result_o, prev);
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done_o || busy_o) saw = 1'b1;
      end
      check("no done after flush", W'(saw), '0);

      // Flush in FIX (cycle T+33) suppresses done_o and the result update
      @(negedge clk);
      op_i       = 2'b01;
      dividend_i = 32'd77;
      divisor_i  = 32'd7;
      start_i    = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (33) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      saw     = done_o;
      repeat (5) begin
         @(negedge clk);
         if (done_o || busy_o) saw = 1'b1;
      end
      check("flush in FIX no done", W'(saw), '0);
      check("flush in FIX result held", result_o, prev);

      // start_i together with flush_i in IDLE is ignored
      op_i       = 2'b01;
      dividend_i = 32'd8;
      divisor_i  = 32'd0;
      start_i    = 1'b1;
      flush_i    = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      flush_i = 1'b0;
      check("start with flush ignored", W'(busy_o), '0);
      check("start with flush result", result_o, prev);

      // Randomized operations against the reference model
      for (int i = 0; i < 60; i++) begin
         logic [1:0]   op;
         logic [W-1:0] a;
         logic [W-1:0] b;
         int           sel;
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 15);
         if (sel < 2) b = '0;
         else if (sel < 5) b = W'($urandom_range(1, 20));
         else if (sel == 5) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (sel == 6) b = 32'hFFFF_FFFF;
         run_op(op, a, b, 0, res, lat, busy_ok);
         check($sformatf("rand[%0d] op%0d %h/%h result", i, op, a, b), res, ref_model(op, a, b));
         check($sformatf("rand[%0d] latency", i), W'(lat), W'(ref_latency(op, a, b)));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
